// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one data memory: round-robin with a MAX_BURST cap on consecutive grants.
// Optional macro MEM_ARB_FIXED_PRIO_EN: port A always wins and preempts B, no burst cap.
module mem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        we_a,
  input  logic        we_b,
  input  logic [5:0]  addr_a,
  input  logic [5:0]  addr_b,
  input  logic [7:0]  wd_a,
  input  logic [7:0]  wd_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        rvalid_a,
  output logic        rvalid_b,
  output logic [7:0]  rd_a,
  output logic [7:0]  rd_b,
  output logic        mem_we,
  output logic [11:0] mem_ra,
  output logic [7:0]  mem_wd,
  input  logic [7:0]  mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       rr_b_q, rr_b_d;
  logic       rvalid_a_q, rvalid_a_d;
  logic       rvalid_b_q, rvalid_b_d;
  logic [7:0] rd_a_q, rd_a_d;
  logic [7:0] rd_b_q, rd_b_d;
  logic       burst_done;

  assign burst_done = (burst_cnt_q == BURST_LAST);
  assign rvalid_a   = rvalid_a_q;
  assign rvalid_b   = rvalid_b_q;
  assign rd_a       = rd_a_q;
  assign rd_b       = rd_b_q;

  always_comb begin
    gnt_a  = (state_q == OWN_A) & req_a;
    gnt_b  = (state_q == OWN_B) & req_b;
    mem_we = 1'b0;
    mem_ra = '0;
    mem_wd = '0;
    if (gnt_a) begin
      mem_we = we_a;
      mem_ra = {addr_a, addr_a};
      mem_wd = wd_a;
    end else if (gnt_b) begin
      mem_we = we_b;
      mem_ra = {addr_b, addr_b};
      mem_wd = wd_b;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          state_d = OWN_A;
`else
          state_d = rr_b_q ? OWN_A : OWN_B;
`endif
        end else if (req_a) begin
          state_d = OWN_A;
        end else if (req_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        if (!req_a) begin
          state_d = req_b ? OWN_B : IDLE;
`ifndef MEM_ARB_FIXED_PRIO_EN
        end else if (req_b && burst_done) begin
          state_d = OWN_B;
`endif
        end
      end
      OWN_B: begin
        if (!req_b) begin
          state_d = req_a ? OWN_A : IDLE;
`ifdef MEM_ARB_FIXED_PRIO_EN
        end else if (req_a) begin
          state_d = OWN_A;
`else
        end else if (req_a && burst_done) begin
          state_d = OWN_A;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter saturates at the last burst slot so an uncontested owner keeps it armed.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_d != state_q) begin
      burst_cnt_d = '0;
    end else if ((gnt_a || gnt_b) && !burst_done) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end

    rr_b_d = rr_b_q;
    if (gnt_a) begin
      rr_b_d = 1'b0;
    end else if (gnt_b) begin
      rr_b_d = 1'b1;
    end

    rvalid_a_d = gnt_a & ~we_a;
    rvalid_b_d = gnt_b & ~we_b;
    rd_a_d     = rvalid_a_d ? mem_rd : rd_a_q;
    rd_b_d     = rvalid_b_d ? mem_rd : rd_b_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      rr_b_q      <= 1'b1;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rr_b_q      <= rr_b_d;
      rvalid_a_q  <= rvalid_a_d;
      rvalid_b_q  <= rvalid_b_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a driver pushes per-cycle expectations from a
// behavioural ownership model; a monitor pops and compares them at each falling edge.
module tb_mem_arbiter;

  localparam int unsigned MB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, we_a, we_b;
  logic [5:0]  addr_a, addr_b;
  logic [7:0]  wd_a, wd_b;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0]  rd_a, rd_b;
  logic        mem_we;
  logic [11:0] mem_ra;
  logic [7:0]  mem_wd, mem_rd;

  logic [7:0]  env_mem [64];
  logic [7:0]  ref_mem [64];

  always #5 clk = ~clk;

  assign mem_rd = env_mem[mem_ra[11:6]];

  mem_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wd_a(wd_a), .wd_b(wd_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .rd_a(rd_a), .rd_b(rd_b),
    .mem_we(mem_we), .mem_ra(mem_ra), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  typedef struct packed {
    logic        ga;
    logic        gb;
    logic        we;
    logic [11:0] ra;
    logic [7:0]  wd;
    logic        rva;
    logic        rvb;
    logic [7:0]  rda;
    logic [7:0]  rdb;
  } exp_t;

  exp_t       cyc_q[$];
  logic [7:0] rda_q[$];
  logic [7:0] rdb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  // Model: owner 0 = nobody, 1 = A, 2 = B; run = grants since owner took over.
  int unsigned m_owner, m_run, m_last;
  logic        m_rva, m_rvb;
  logic [7:0]  m_rda, m_rdb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_run   = 0;
    m_last  = 2;
    m_rva   = 1'b0;
    m_rvb   = 1'b0;
    m_rda   = '0;
    m_rdb   = '0;
    rda_q.delete();
    rdb_q.delete();
  endtask

  task automatic step(input logic rst_v, input logic ra, input logic rb,
                      input logic wea, input logic web,
                      input logic [5:0] aa, input logic [5:0] ab,
                      input logic [7:0] da, input logic [7:0] db);
    exp_t        e;
    logic        ga, gb, own_req, oth_req;
    int unsigned nxt, other;
    @(posedge clk);
    #1;
    reset = rst_v; req_a = ra; req_b = rb; we_a = wea; we_b = web;
    addr_a = aa; addr_b = ab; wd_a = da; wd_b = db;
    if (!rst_v) model_reset();
    ga = rst_v && (m_owner == 1) && ra;
    gb = rst_v && (m_owner == 2) && rb;
    e.ga  = ga;
    e.gb  = gb;
    e.we  = (ga && wea) || (gb && web);
    e.ra  = ga ? {aa, aa} : (gb ? {ab, ab} : 12'h000);
    e.wd  = ga ? da : (gb ? db : 8'h00);
    e.rva = m_rva;
    e.rvb = m_rvb;
    e.rda = m_rda;
    e.rdb = m_rdb;
    cyc_q.push_back(e);
    if (rst_v) begin
      m_rva = ga && !wea;
      m_rvb = gb && !web;
      if (m_rva) begin m_rda = ref_mem[aa]; rda_q.push_back(m_rda); end
      if (m_rvb) begin m_rdb = ref_mem[ab]; rdb_q.push_back(m_rdb); end
      if (ga && wea) ref_mem[aa] = da;
      if (gb && web) ref_mem[ab] = db;
      if (ga) m_last = 1;
      if (gb) m_last = 2;
      if (m_owner == 0) begin
        if (ra && rb) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          nxt = 1;
`else
          nxt = (m_last == 2) ? 1 : 2;
`endif
        end else if (ra) nxt = 1;
        else if (rb)     nxt = 2;
        else             nxt = 0;
      end else begin
        other   = 3 - m_owner;
        own_req = (m_owner == 1) ? ra : rb;
        oth_req = (m_owner == 1) ? rb : ra;
        if (!own_req) begin
          nxt = oth_req ? other : 0;
        end else begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          nxt = (m_owner == 2 && ra) ? 1 : m_owner;
`else
          nxt = (oth_req && (m_run + 1 >= MB)) ? other : m_owner;
`endif
        end
      end
      if (nxt != m_owner) m_run = 0;
      else if (ga || gb)  m_run = m_run + 1;
      m_owner = nxt;
    end
    #2;
    if (mem_we) env_mem[mem_ra[5:0]] = mem_wd;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 8'h00, 8'h00);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("gnt_exclusive", {31'b0, gnt_a & gnt_b}, 32'd0);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("gnt_a", {31'b0, gnt_a}, {31'b0, e.ga});
        chk("gnt_b", {31'b0, gnt_b}, {31'b0, e.gb});
        chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
        chk("mem_ra", {20'b0, mem_ra}, {20'b0, e.ra});
        chk("mem_wd", {24'b0, mem_wd}, {24'b0, e.wd});
        chk("rvalid_a", {31'b0, rvalid_a}, {31'b0, e.rva});
        chk("rvalid_b", {31'b0, rvalid_b}, {31'b0, e.rvb});
        chk("rd_a_hold", {24'b0, rd_a}, {24'b0, e.rda});
        chk("rd_b_hold", {24'b0, rd_b}, {24'b0, e.rdb});
      end
      if (rvalid_a) begin
        if (rda_q.size() == 0) chk("rvalid_a_unexpected", {31'b0, rvalid_a}, 32'd0);
        else chk("rd_a_return", {24'b0, rd_a}, {24'b0, rda_q.pop_front()});
      end
      if (rvalid_b) begin
        if (rdb_q.size() == 0) chk("rvalid_b_unexpected", {31'b0, rvalid_b}, 32'd0);
        else chk("rd_b_return", {24'b0, rd_b}, {24'b0, rdb_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin
    logic       rst_v, ra, rb;
    logic [7:0] v;
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; wd_a = '0; wd_b = '0;
    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom);
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    model_reset();

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 8'h00, 8'h00);

    // Lone write to addr 5, then read it back
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 6'd0, 8'h3C, 8'h00);
    idle(1);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 6'd0, 8'h00, 8'h00);
    idle(2);

    // B alone, then a tie from IDLE must go to A, then sustained contention
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 6'd9, 8'h00, 8'h5A);
    idle(1);
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 1'b1, 1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)),
           6'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    idle(2);

    // Reset pulsed the cycle after a granted read
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 6'd0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 6'd0, 8'h00, 8'h00);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd5, 6'd6, 8'h00, 8'h00);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      rst_v = ($urandom_range(0, 199) != 0);
      ra    = ($urandom_range(0, 9) < 7);
      rb    = ($urandom_range(0, 9) < 7);
      step(rst_v, ra, rb, 1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)),
           6'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    end
    idle(3);

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drain", cyc_q.size(), 32'd0);
    chk("rd_a_pending", rda_q.size(), 32'd0);
    chk("rd_b_pending", rdb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum number of consecutive granted cycles for one owner while the other port waits (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports req_a, req_b, input, 1 each, meaning the port requests one memory access per cycle while high.
REQ-005 SHALL have ports we_a, we_b, input, 1 each, meaning write (1) or read (0) for the port's access.
REQ-006 SHALL have ports addr_a, addr_b, input, 6 each, meaning the word address.
REQ-007 SHALL have ports wd_a, wd_b, input, 8 each, meaning the write data.
REQ-008 SHALL have ports gnt_a, gnt_b, output, 1 each, meaning the access is performed this cycle.
REQ-009 SHALL have ports rvalid_a, rvalid_b, output, 1 each, and rd_a, rd_b, output, 8 each, meaning registered read return.
REQ-010 SHALL have port mem_we, output, 1, meaning the data-memory write enable.
REQ-011 SHALL have port mem_ra, output, 12, meaning the data-memory address: owner address on [11:6] (read field) and [5:0] (write field).
REQ-012 SHALL have port mem_wd, output, 8, and mem_rd, input, 8, meaning memory write data and combinational read data.

Function
REQ-013 SHALL implement FSM states IDLE, OWN_A, OWN_B; gnt_x = (state==OWN_x) & req_x, and gnt_a & gnt_b never both high.
REQ-014 IDLE: only req_a -> OWN_A; only req_b -> OWN_B; both -> port not served last (rr pointer); neither -> IDLE.
REQ-015 Request-to-grant latency SHALL be exactly 1 cycle from IDLE; a request rising in IDLE is never granted the same cycle.
REQ-016 OWN_x with req_x low: move to the other owner if it requests, else IDLE; no grant that cycle.
REQ-017 OWN_x with req_x high: burst_cnt increments per granted cycle; when burst_cnt==MAX_BURST-1 and the other port requests, move to the other owner at the next edge, else stay.
REQ-018 burst_cnt (4 bits) SHALL clear on every state change and saturate at MAX_BURST-1 when uncontested.
REQ-019 rr pointer SHALL record the last port granted and update on every grant.
REQ-020 mem_we = gnt & we of owner; mem_wd, mem_ra driven from owner; with no grant mem_we=0, mem_ra=0, mem_wd=0.
REQ-021 Read granted in cycle N SHALL raise rvalid_x for exactly cycle N+1 with rd_x = mem_rd sampled at edge ending N; rd_x holds its value otherwise.
REQ-022 Write then read of the same address by consecutive grants SHALL return the new data.

Reset
REQ-023 On reset low: state IDLE, rr pointer = B (so A wins first tie), burst_cnt 0, all gnt/rvalid/mem_we 0, rd_a/rd_b 0, mem_ra/mem_wd 0.
REQ-024 Reset asserted mid-burst SHALL drop any pending rvalid; first grant after release follows REQ-015.

Configuration
REQ-025 Macro MEM_ARB_FIXED_PRIO_EN defined: port A wins every tie, OWN_B moves to OWN_A at next edge whenever req_a high, burst limit applies to neither port.
REQ-026 Macro undefined: round-robin plus MAX_BURST limit per REQ-014..REQ-019.

Verification
REQ-027 Reset low, then req_a=1 we_a=1 addr_a=5 wd_a=8'h3C alone -> gnt_a high from cycle 2, mem_we=1, mem_ra=12'h145, mem_wd=8'h3C.
REQ-028 A read of addr 5 after the above -> rvalid_a one cycle after gnt_a, rd_a=8'h3C.
REQ-029 req_a and req_b both held, MAX_BURST=4, macro off -> grants A,A,A,A,B,B,B,B,A...; never both gnt.
REQ-030 Same stimulus with MEM_ARB_FIXED_PRIO_EN -> gnt_a continuous, gnt_b never high.
REQ-031 req_b alone for 3 cycles then req_a and req_b together from IDLE -> gnt_a wins (rr pointer = B).
REQ-032 Reset pulsed the cycle after a granted read -> rvalid stays 0, state IDLE, outputs 0.
